alu_seq_core: RTL
=================

# alu_seq_core

Sequential, handshake-driven 8-bit ALU responder. It accepts one command per transaction from an initiator over a valid/ready request channel, executes it, and returns a 16-bit result over a valid/ready response channel. Command encoding and operand/result widths match the team's combinational ALU. Multiply and divide are iterative, taking 8 cycles, so the block replaces wide combinational multiply/divide wherever timing closure matters.

## Interface
- No parameters; widths fixed at 8-bit operands, 16-bit result.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- a_in  in  8  signed operand A
- b_in  in  8  signed operand B
- command_in  in  4  opcode: ADD 0, INC 1, SUB 2, DEC 3, MUL 4, DIV 5, SHL 6, SHR 7, AND 8, OR 9, INV 10, NAND 11, NOR 12, XOR 13, XNOR 14, BUF 15
- req_valid  in  1  initiator presents a command
- req_ready  out  1  block can accept a command
- rsp_valid  out  1  d_out/err hold a completed result
- rsp_ready  in  1  initiator consumes the result
- oe  in  1  output enable for d_out
- d_out  out  16  result; forced to 16'h0000 when oe=0
- err  out  1  divide-by-zero flag, qualified by rsp_valid
- busy  out  1  high in CALC

## Operation
- State machine:
  - IDLE -> CALC on accept of MUL or DIV with b≠0.
  - IDLE -> DONE on accept of any other command, including DIV with b=0.
  - CALC -> DONE after 8 iteration cycles.
  - DONE -> IDLE when rsp_ready=1.
- Accept condition: req_valid && req_ready. Operands and opcode are registered at accept; later input changes are ignored.
- req_ready = (state==IDLE). There is one outstanding transaction at a time and no pipelining.
- Arithmetic uses sign-extended 16-bit results:
  - ADD: a+b
  - INC: a+1
  - SUB: a-b
  - DEC: a-1
  - SHL: sext(a)<<1, so 8'h80 -> 16'hFF00
  - SHR: arithmetic sext(a)>>>1
- Logic ops compute an 8-bit result, zero-extended to {8'h00, r}:
  - AND, OR, NAND, NOR, XOR, XNOR: bitwise on a and b
  - INV: ~a
  - BUF: a
- MUL: signed 8x8 -> 16. Shift-add on magnitudes, one partial product per CALC cycle, sign fixed on the final cycle.
- DIV: restoring division on magnitudes, one quotient bit per CALC cycle.
  - d_out = {remainder[7:0], quotient[7:0]}.
  - Quotient truncates toward zero; remainder takes the sign of a.
  - -128/-1 gives quotient 8'h80, remainder 8'h00, err=0 (wraps, not flagged).
- DIV with b=0: d_out=16'hFFFF, err=1, no CALC phase.
- err is cleared on every accept. It is 0 for all non-DIV results.
- oe gates only d_out. Handshakes, state and the internal result register are unaffected by oe. Raising oe exposes the held result immediately (combinational).

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, busy=0, err=0, internal result 0, so d_out=16'h0000.
- Single-cycle ops: accept at edge N; rsp_valid=1 and result valid after edge N+1.
- MUL/DIV: accept at edge N; busy=1 for edges N+1..N+8; rsp_valid=1 after edge N+9.
- rsp_valid, d_out and err hold stable while rsp_valid && !rsp_ready.
- On the handshake edge rsp_valid drops and req_ready rises. The next accept occurs one edge later at the earliest, so back-to-back throughput is one result per 2 cycles for single-cycle ops.
- Reset mid-operation (rst_n=0 at any edge) aborts CALC or DONE, discards the result and applies the reset values at that edge.
- req_valid while not ready: the request is held by the initiator and not accepted. The block has no buffering.

## Test plan
- After reset, req_ready=1, rsp_valid=0, d_out=0. ADD a=25, b=17, oe=1 -> rsp_valid one cycle after accept, d_out=16'd42, err=0.
- MUL a=-3, b=5 -> busy for 8 cycles, rsp_valid 9 cycles after accept, d_out=16'hFFF1. MUL a=-128, b=-128 -> 16'h4000.
- DIV a=-7, b=2 -> d_out=16'hFFFD (rem -1, quo -3). DIV a=9, b=0 -> d_out=16'hFFFF, err=1, latency 1.
- Logic/shift ops with a=8'hF0, b=8'h3C:
  - AND -> 16'h0030
  - XNOR -> 16'h0033
  - SHL -> 16'hFFE0
  - SHR -> 16'hFFF8
- Backpressure: hold rsp_ready=0 for 5 cycles after SUB 10-20 -> d_out=16'hFFF6 stable, req_ready=0, a second request not accepted until after the handshake. Toggle oe=0 -> d_out=0; oe=1 -> 16'hFFF6 returns.
- Reset mid-MUL at CALC cycle 4 -> next edge: IDLE, busy=0, rsp_valid=0, d_out=0. A following ADD 1+1 completes normally with 16'd2.

Source files
------------

// File: rtl/alu_seq_core.sv
// alu_seq_core
//   Sequential 8-bit ALU responder behind a valid/ready request channel and a
//   valid/ready response channel. Single-cycle ops finish one cycle after
//   accept; MUL (shift-add) and DIV (restoring) iterate for 8 cycles on
//   operand magnitudes, with the sign applied on the last iteration.
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   a_in, b_in          signed 8-bit operands (captured at accept)
//   command_in          4-bit opcode (captured at accept)
//   req_valid/req_ready request handshake; ready only in IDLE
//   rsp_valid/rsp_ready response handshake; result held until consumed
//   oe                  output enable; d_out reads zero when low
//   d_out               16-bit result
//   err                 divide-by-zero flag, meaningful while rsp_valid
//   busy                high while iterating (CALC)
module alu_seq_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    input  logic [3:0]  command_in,
    input  logic        req_valid,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    input  logic        oe,
    output logic [15:0] d_out,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_INC, OP_SUB, OP_DEC, OP_MUL, OP_DIV, OP_SHL, OP_SHR,
        OP_AND, OP_OR, OP_INV, OP_NAND, OP_NOR, OP_XOR, OP_XNOR, OP_BUF
    } op_t;

    state_t      state_q, state_d;
    logic [15:0] result_q, result_d;
    logic        err_q, err_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;      // sign of product / quotient
    logic        rneg_q, rneg_d;    // sign of remainder (follows a)
    logic [15:0] acc_q, acc_d;      // MUL partial-product accumulator
    logic [15:0] mcand_q, mcand_d;  // MUL multiplicand, shifted left per step
    logic [7:0]  opb_q, opb_d;      // MUL multiplier (shifted right) / DIV divisor
    logic [7:0]  rem_q, rem_d;      // DIV partial remainder
    logic [7:0]  quo_q, quo_d;      // DIV dividend shifting out, quotient shifting in

    logic [15:0] sa, sb, single_res;
    logic [7:0]  a_mag, b_mag;
    logic [15:0] acc_n;
    logic [8:0]  rem_sh;
    logic [7:0]  rem_n, quo_n, q_fix, r_fix;
    logic        q_bit;

    assign sa    = {{8{a_in[7]}}, a_in};
    assign sb    = {{8{b_in[7]}}, b_in};
    assign a_mag = a_in[7] ? (~a_in + 8'd1) : a_in;
    assign b_mag = b_in[7] ? (~b_in + 8'd1) : b_in;

    // Results for ops that complete straight from the accepted inputs.
    always_comb begin
        single_res = '0;
        case (op_t'(command_in))
            OP_ADD:  single_res = sa + sb;
            OP_INC:  single_res = sa + 16'd1;
            OP_SUB:  single_res = sa - sb;
            OP_DEC:  single_res = sa - 16'd1;
            OP_MUL:  single_res = '0;
            OP_DIV:  single_res = '0;
            OP_SHL:  single_res = sa << 1;
            OP_SHR:  single_res = {a_in[7], sa[15:1]};
            OP_AND:  single_res = {8'h00, a_in & b_in};
            OP_OR:   single_res = {8'h00, a_in | b_in};
            OP_INV:  single_res = {8'h00, ~a_in};
            OP_NAND: single_res = {8'h00, ~(a_in & b_in)};
            OP_NOR:  single_res = {8'h00, ~(a_in | b_in)};
            OP_XOR:  single_res = {8'h00, a_in ^ b_in};
            OP_XNOR: single_res = {8'h00, ~(a_in ^ b_in)};
            OP_BUF:  single_res = {8'h00, a_in};
        endcase
    end

    // One iteration step of each engine.
    always_comb begin
        acc_n  = acc_q + (opb_q[0] ? mcand_q : 16'h0000);
        rem_sh = {rem_q, quo_q[7]};
        q_bit  = (rem_sh >= {1'b0, opb_q});
        // True difference is below 256, so the low byte is exact.
        rem_n  = q_bit ? (rem_sh[7:0] - opb_q) : rem_sh[7:0];
        quo_n  = {quo_q[6:0], q_bit};
        q_fix  = neg_q  ? (~quo_n + 8'd1) : quo_n;
        r_fix  = rneg_q ? (~rem_n + 8'd1) : rem_n;
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        opb_d    = opb_q;
        rem_d    = rem_q;
        quo_d    = quo_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    err_d  = 1'b0;
                    cnt_d  = '0;
                    neg_d  = a_in[7] ^ b_in[7];
                    rneg_d = a_in[7];
                    if (op_t'(command_in) == OP_MUL) begin
                        is_div_d = 1'b0;
                        acc_d    = '0;
                        mcand_d  = {8'h00, a_mag};
                        opb_d    = b_mag;
                        state_d  = CALC;
                    end else if (op_t'(command_in) == OP_DIV) begin
                        if (b_in == 8'h00) begin
                            result_d = '1;
                            err_d    = 1'b1;
                            state_d  = DONE;
                        end else begin
                            is_div_d = 1'b1;
                            rem_d    = '0;
                            quo_d    = a_mag;
                            opb_d    = b_mag;
                            state_d  = CALC;
                        end
                    end else begin
                        result_d = single_res;
                        state_d  = DONE;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 3'd1;
                if (is_div_q) begin
                    rem_d = rem_n;
                    quo_d = quo_n;
                end else begin
                    acc_d   = acc_n;
                    mcand_d = mcand_q << 1;
                    opb_d   = opb_q >> 1;
                end
                if (cnt_q == 3'd7) begin
                    if (is_div_q) result_d = {r_fix, q_fix};
                    else          result_d = neg_q ? (~acc_n + 16'd1) : acc_n;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            opb_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            opb_q    <= opb_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q == CALC);
    assign err       = err_q;
    assign d_out     = oe ? result_q : 16'h0000;

endmodule
